// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU pipeline control slice: scoreboard entry layout,
// forwarding-select encoding and the hazard controller FSM states.
package cpu_ctrl_pkg;

  localparam int REG_AW    = 4;
  localparam int OPCODE_W  = 4;
  localparam int REGNUM    = 2 ** REG_AW;

  typedef logic [REG_AW-1:0]   reg_idx_t;
  typedef logic [OPCODE_W-1:0] opcode_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } ctrl_state_e;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     writes;
    logic     is_load;
    logic     is_multi;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     uses1;
    logic     uses2;
  } sb_entry_t;

  function automatic logic src_match(input logic uses, input reg_idx_t rs,
                                     input reg_idx_t rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one EX operand. MEM wins over WB because it holds
// the younger write; a load in MEM has no data yet, so it never forwards.
module hazard_fwd_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDRESSWIDTH = REG_AW
) (
  input  logic                    uses,
  input  logic [ADDRESSWIDTH-1:0] rs,
  input  logic                    mem_valid,
  input  logic                    mem_writes,
  input  logic                    mem_is_load,
  input  logic [ADDRESSWIDTH-1:0] mem_rd,
  input  logic                    wb_valid,
  input  logic                    wb_writes,
  input  logic [ADDRESSWIDTH-1:0] wb_rd,
  output logic [1:0]              sel
);

  fwd_sel_e sel_e;

  always_comb begin
    sel_e = FWD_RF;
    if (uses && mem_valid && mem_writes && !mem_is_load && (mem_rd == rs)) begin
      sel_e = FWD_EXMEM;
    end else if (uses && wb_valid && wb_writes && (wb_rd == rs)) begin
      sel_e = FWD_MEMWB;
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/bubble/forwarding control for the 5-stage pipeline, driven by a
// shadow scoreboard of the EX, MEM and WB instructions.
module pipeline_hazard_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDRESSWIDTH = REG_AW,
  parameter int MULCYCLES    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [ADDRESSWIDTH-1:0] id_rs1,
  input  logic [ADDRESSWIDTH-1:0] id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic [ADDRESSWIDTH-1:0] id_rd,
  input  logic                    id_writes_rd,
  input  logic                    id_is_load,
  input  logic                    id_is_multi,
  input  logic                    ex_branch_taken,
  output logic                    stall_fetch,
  output logic                    stall_decode,
  output logic                    flush_decode,
  output logic                    bubble_ex,
  output logic [1:0]              fwd_a,
  output logic [1:0]              fwd_b,
  output logic                    busy
);

  localparam bit MULTI_EN = (MULCYCLES > 1);
  localparam int CW       = (MULCYCLES > 2) ? $clog2(MULCYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULTI_EN ? MULCYCLES - 2 : 0);

  ctrl_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  sb_entry_t     ex_q, mem_q, wb_q;
  sb_entry_t     ex_nxt, mem_nxt, wb_nxt;
  sb_entry_t     id_entry;
  logic          rst_d;
  logic          quiet;

  logic          load_use, multi_start;
  logic          stall_raw, flush_raw, bubble_raw, busy_raw;
  logic [1:0]    fwd_a_raw, fwd_b_raw;
  logic          unused_wb;

  always_comb begin
    id_entry = '{valid:    id_valid,
                 rd:       id_rd,
                 writes:   id_writes_rd,
                 is_load:  id_is_load,
                 is_multi: id_is_multi,
                 rs1:      id_rs1,
                 rs2:      id_rs2,
                 uses1:    id_uses_rs1,
                 uses2:    id_uses_rs2};
  end

  assign load_use = ex_q.valid && ex_q.is_load && ex_q.writes && id_valid &&
                    (src_match(id_uses_rs1, id_rs1, ex_q.rd) ||
                     src_match(id_uses_rs2, id_rs2, ex_q.rd));

  assign multi_start = MULTI_EN && ex_q.valid && ex_q.is_multi;

  // The entry cycle of a multi-cycle op already holds EX, so a MULCYCLES=N op
  // stalls N-1 cycles and the pipeline moves again when the counter hits 0.
  always_comb begin
    stall_raw  = 1'b0;
    flush_raw  = 1'b0;
    bubble_raw = 1'b0;
    busy_raw   = 1'b0;
    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          flush_raw  = 1'b1;
          bubble_raw = 1'b1;
        end else if (multi_start) begin
          stall_raw = 1'b1;
          busy_raw  = 1'b1;
        end else if (load_use) begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
        end
      end
      MULTI: begin
        if (cnt != '0) begin
          stall_raw = 1'b1;
          busy_raw  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  hazard_fwd_unit #(.ADDRESSWIDTH(ADDRESSWIDTH)) u_fwd_a (
    .uses        (ex_q.uses1),
    .rs          (ex_q.rs1),
    .mem_valid   (mem_q.valid),
    .mem_writes  (mem_q.writes),
    .mem_is_load (mem_q.is_load),
    .mem_rd      (mem_q.rd),
    .wb_valid    (wb_q.valid),
    .wb_writes   (wb_q.writes),
    .wb_rd       (wb_q.rd),
    .sel         (fwd_a_raw)
  );

  hazard_fwd_unit #(.ADDRESSWIDTH(ADDRESSWIDTH)) u_fwd_b (
    .uses        (ex_q.uses2),
    .rs          (ex_q.rs2),
    .mem_valid   (mem_q.valid),
    .mem_writes  (mem_q.writes),
    .mem_is_load (mem_q.is_load),
    .mem_rd      (mem_q.rd),
    .wb_valid    (wb_q.valid),
    .wb_writes   (wb_q.writes),
    .wb_rd       (wb_q.rd),
    .sel         (fwd_b_raw)
  );

  // Everything is silent while reset is high and for one cycle after it.
  assign quiet        = reset || rst_d;
  assign stall_fetch  = stall_raw  && !quiet;
  assign stall_decode = stall_raw  && !quiet;
  assign flush_decode = flush_raw  && !quiet;
  assign bubble_ex    = bubble_raw && !quiet;
  assign busy         = busy_raw   && !quiet;
  assign fwd_a        = quiet ? 2'b00 : fwd_a_raw;
  assign fwd_b        = quiet ? 2'b00 : fwd_b_raw;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ex_nxt    = ex_q;
    mem_nxt   = mem_q;
    wb_nxt    = wb_q;

    if (busy) begin
      mem_nxt = '0;
      wb_nxt  = mem_q;
    end else begin
      ex_nxt  = (id_valid && !bubble_ex) ? id_entry : '0;
      mem_nxt = ex_q;
      wb_nxt  = mem_q;
    end

    case (state)
      RUN: begin
        if (busy) begin
          state_nxt = MULTI;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MULTI: begin
        if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    rst_d <= reset;
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ex_q  <= ex_nxt;
      mem_q <= mem_nxt;
      wb_q  <= wb_nxt;
    end
  end

  // WB only needs valid/writes/rd; the rest of the entry rides along.
  assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: hand-computed control vectors
// {stall_fetch, stall_decode, flush_decode, bubble_ex, fwd_a, fwd_b, busy}.
module tb_pipeline_hazard_controller;

  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_uses_rs1, id_uses_rs2, id_writes_rd;
  logic          id_is_load, id_is_multi;
  logic          ex_branch_taken;
  logic          stall_fetch, stall_decode, flush_decode, bubble_ex, busy;
  logic [1:0]    fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_controller #(.ADDRESSWIDTH(AW), .MULCYCLES(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd           (id_rd),
    .id_writes_rd    (id_writes_rd),
    .id_is_load      (id_is_load),
    .id_is_multi     (id_is_multi),
    .ex_branch_taken (ex_branch_taken),
    .stall_fetch     (stall_fetch),
    .stall_decode    (stall_decode),
    .flush_decode    (flush_decode),
    .bubble_ex       (bubble_ex),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic set_id(input logic v, input int rs1, input logic u1,
                        input int rs2, input logic u2, input int rd,
                        input logic wr, input logic ld, input logic mu);
    id_valid     = v;
    id_rs1       = AW'(rs1);
    id_uses_rs1  = u1;
    id_rs2       = AW'(rs2);
    id_uses_rs2  = u2;
    id_rd        = AW'(rd);
    id_writes_rd = wr;
    id_is_load   = ld;
    id_is_multi  = mu;
  endtask

  task automatic id_none();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {stall_fetch, stall_decode, flush_decode, bubble_ex, fwd_a, fwd_b, busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Negedge drive, settle, then compare before the next rising edge.
  task automatic settle();
    #1;
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      assert (!(busy && ex_branch_taken)) else begin
        errors++;
        $error("FAIL branch_in_multi: observed busy=%b branch=%b expected no overlap",
               busy, ex_branch_taken);
      end
    end
  end

  initial begin
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    id_none();

    // Reset with random inputs for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      set_id(1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
             $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ex_branch_taken = 1'($urandom_range(0, 1));
      settle();
      chk("reset_outputs_zero", 9'b0_0_0_0_00_00_0);
    end

    // First cycle after release: ADD r3 <= r1,r2
    @(negedge clock);
    reset = 1'b0;
    ex_branch_taken = 1'b0;
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0);
    settle();
    chk("post_reset_quiet", 9'b0_0_0_0_00_00_0);

    // SUB r4 <= r3,r6 ; EX=ADD
    @(negedge clock);
    set_id(1'b1, 3, 1'b1, 6, 1'b1, 4, 1'b1, 1'b0, 1'b0);
    settle();
    chk("add_in_ex_no_hazard", 9'b0_0_0_0_00_00_0);

    // OR r7 <= r8,r9 ; EX=SUB, MEM=ADD r3 -> fwd_a EX/MEM
    @(negedge clock);
    set_id(1'b1, 8, 1'b1, 9, 1'b1, 7, 1'b1, 1'b0, 1'b0);
    settle();
    chk("fwd_a_exmem", 9'b0_0_0_0_01_00_0);

    // AND r10 <= r4,r11 ; EX=OR (independent)
    @(negedge clock);
    set_id(1'b1, 4, 1'b1, 11, 1'b1, 10, 1'b1, 1'b0, 1'b0);
    settle();
    chk("independent_op", 9'b0_0_0_0_00_00_0);

    // LOAD r5 <= [r12] ; EX=AND, WB=SUB r4 -> fwd_a MEM/WB
    @(negedge clock);
    set_id(1'b1, 12, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0);
    settle();
    chk("fwd_a_memwb", 9'b0_0_0_0_10_00_0);

    // ADD r6 <= r13,r5 ; EX=LOAD r5 -> load-use stall + bubble
    @(negedge clock);
    set_id(1'b1, 13, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0);
    settle();
    chk("load_use_stall", 9'b1_1_0_1_00_00_0);

    // Same ADD held in ID ; EX=bubble -> stall lasts one cycle
    @(negedge clock);
    settle();
    chk("load_use_one_cycle", 9'b0_0_0_0_00_00_0);

    // XOR r6 <= r1,r2 ; EX=ADD(r13,r5), WB=LOAD r5 -> fwd_b MEM/WB
    @(negedge clock);
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 6, 1'b1, 1'b0, 1'b0);
    settle();
    chk("load_fwd_b_memwb", 9'b0_0_0_0_00_10_0);

    // ADD r9 <= r6,r6 ; EX=XOR
    @(negedge clock);
    set_id(1'b1, 6, 1'b1, 6, 1'b1, 9, 1'b1, 1'b0, 1'b0);
    settle();
    chk("xor_in_ex", 9'b0_0_0_0_00_00_0);

    // EX=ADD(r6,r6), MEM=XOR r6, WB=ADD r6 -> MEM wins on both operands
    @(negedge clock);
    id_none();
    settle();
    chk("mem_priority_over_wb", 9'b0_0_0_0_01_01_0);

    // LOAD r2 <= [r0]
    @(negedge clock);
    set_id(1'b1, 0, 1'b1, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0);
    settle();
    chk("load_r2_enters", 9'b0_0_0_0_00_00_0);

    // ID consumer of r2 while EX load + taken branch -> flush beats stall
    @(negedge clock);
    set_id(1'b1, 2, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    settle();
    chk("branch_beats_load_use", 9'b0_0_1_1_00_00_0);

    // EX bubbled by the branch, MEM=LOAD r2 (loads never forward from MEM)
    @(negedge clock);
    ex_branch_taken = 1'b0;
    id_none();
    settle();
    chk("after_branch", 9'b0_0_0_0_00_00_0);

    // MUL r8 <= r1,r2
    @(negedge clock);
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 8, 1'b1, 1'b0, 1'b1);
    settle();
    chk("mul_enters", 9'b0_0_0_0_00_00_0);

    // ADD r10 <= r8,r3 waits three cycles behind the MUL
    @(negedge clock);
    set_id(1'b1, 8, 1'b1, 3, 1'b1, 10, 1'b1, 1'b0, 1'b0);
    settle();
    chk("mul_hold_1", 9'b1_1_0_0_00_00_1);
    @(negedge clock);
    settle();
    chk("mul_hold_2", 9'b1_1_0_0_00_00_1);
    @(negedge clock);
    settle();
    chk("mul_hold_3", 9'b1_1_0_0_00_00_1);
    @(negedge clock);
    settle();
    chk("mul_release", 9'b0_0_0_0_00_00_0);

    // EX=ADD(r8), MEM=MUL r8, WB=bubble from the hold
    @(negedge clock);
    id_none();
    settle();
    chk("mul_result_fwd", 9'b0_0_0_0_01_00_0);

    // MUL r11, then reset while its counter is at 1
    @(negedge clock);
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 11, 1'b1, 1'b0, 1'b1);
    settle();
    chk("mul2_enters", 9'b0_0_0_0_00_00_0);
    @(negedge clock);
    set_id(1'b1, 11, 1'b1, 11, 1'b1, 12, 1'b1, 1'b0, 1'b0);
    settle();
    chk("mul2_hold_1", 9'b1_1_0_0_00_00_1);
    @(negedge clock);
    settle();
    chk("mul2_hold_2", 9'b1_1_0_0_00_00_1);
    @(negedge clock);
    reset = 1'b1;
    settle();
    chk("reset_in_multi", 9'b0_0_0_0_00_00_0);

    // First cycle after reset: a taken branch must still be silent
    @(negedge clock);
    reset = 1'b0;
    ex_branch_taken = 1'b1;
    settle();
    chk("post_reset2_quiet", 9'b0_0_0_0_00_00_0);

    // EX=ADD(r11,r11), scoreboard otherwise empty, FSM back in RUN
    @(negedge clock);
    ex_branch_taken = 1'b0;
    id_none();
    settle();
    chk("scoreboard_cleared", 9'b0_0_0_0_00_00_0);

    @(negedge clock);
    settle();
    chk("idle_after_reset", 9'b0_0_0_0_00_00_0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: observed no completion, expected finish before 20000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequencing and control block for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB).
- Keeps a shadow scoreboard of destination registers in flight.
- From that scoreboard it generates:
  - IF/ID stall,
  - ID flush,
  - EX bubble insertion,
  - EX operand-forwarding selects.
- Holds EX for multi-cycle operations.
- Instantiated inside CPU beside the pipeline registers; the datapath obeys its outputs.

Parameters:
- ADDRESSWIDTH, 4, register-index width (REGNUM = 2**ADDRESSWIDTH = 16)
- OPCODEWIDTH, 4, opcode width; sized into the shared package only
- MULCYCLES, 4, EX occupancy of a multi-cycle op in cycles, >= 1

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  ADDRESSWIDTH  first source register
- id_rs2  in  ADDRESSWIDTH  second source register
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_rd  in  ADDRESSWIDTH  destination register
- id_writes_rd  in  1  instruction writes rd
- id_is_load  in  1  memory load
- id_is_multi  in  1  multi-cycle EX op
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- stall_fetch  out  1  hold the PC and IF/ID register
- stall_decode  out  1  hold the ID/EX source fields
- flush_decode  out  1  zero the IF/ID register
- bubble_ex  out  1  load a NOP into ID/EX
- fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
- fwd_b  out  2  EX operand B source, same encoding as fwd_a
- busy  out  1  multi-cycle op occupying EX

Behaviour:
- Interface: one clock, `clock`. `reset` is synchronous and active-high.
- Reset:
  - Scoreboard entries EX, MEM and WB are set invalid; FSM goes to RUN; counter is 0.
  - All outputs are 0 while reset is high and in the first cycle after reset.
- Scoreboard:
  - Each entry holds {valid, rd, writes, is_load, rs1, rs2, uses1, uses2}.
  - R0 is an ordinary register with no special casing.
- Advance (RUN, no stall): WB<=MEM, MEM<=EX, EX<=ID entry (ID entry is invalid if id_valid=0 or bubble_ex=1).
- FSM states RUN and MULTI:
  - RUN -> MULTI when a valid multi op is in EX and MULCYCLES>1. The counter loads MULCYCLES-2.
  - MULTI: EX holds and MEM<=invalid while WB<=MEM. stall_fetch=stall_decode=1, busy=1.
  - Counter decrements each cycle. MULTI -> RUN on the cycle the counter is 0; the pipeline advances that cycle.
  - A multi op with MULCYCLES=1 behaves exactly like a normal op.
- Load-use hazard (RUN only): EX.valid & EX.is_load & EX.writes & id_valid & ((id_uses_rs1 & id_rs1==EX.rd) | (id_uses_rs2 & id_rs2==EX.rd)).
  - Response: stall_fetch=stall_decode=bubble_ex=1 for exactly one cycle.
- Branch (RUN only): ex_branch_taken=1 gives flush_decode=1 and bubble_ex=1 in the same cycle, with no stall.
  - Branch beats load-use on the same cycle, because the ID instruction is on the wrong path.
  - ex_branch_taken is ignored in MULTI; a bench assertion checks that it is never asserted there.
- Forwarding, for the EX entry, combinational from the scoreboard:
  - fwd_a=01 if EX.uses1 & MEM.valid & MEM.writes & !MEM.is_load & MEM.rd==EX.rs1.
  - Otherwise fwd_a=10 if EX.uses1 & WB.valid & WB.writes & WB.rd==EX.rs1.
  - Otherwise fwd_a=00.
  - MEM has priority over WB. fwd_b is identical using rs2/uses2. Code 11 is never driven.
- Stall/flush outputs are combinational from the FSM, scoreboard and current inputs; there is no extra latency.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - typedef `fwd_sel_e` {FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10};
  - typedef `ctrl_state_e` {RUN, MULTI};
  - struct `sb_entry_t`.
- One sub-module, `hazard_fwd_unit`: purely combinational forwarding comparison for one operand, instantiated twice (A and B).

Test Plan:
- Reset held 2 cycles with random inputs -> all outputs 0 and busy=0; the first instruction after release advances with no stall.
- ADD r3 writes, then SUB reads r3 as rs1 next cycle -> fwd_a=01 in SUB's EX cycle; with one independent op between them -> fwd_a=10.
- LOAD r5, then ADD reads r5 as rs2 -> one cycle with stall_fetch=stall_decode=bubble_ex=1; in ADD's EX cycle fwd_b=10.
- Taken branch in EX while ID holds a load-use consumer -> flush_decode=1, bubble_ex=1, stall_fetch=0 that cycle.
- Multi op with MULCYCLES=4 -> busy=1 and stalls held for exactly 3 cycles, EX/MEM bubbles reach WB, and the following op advances on cycle 4.
- Reset asserted during MULTI with counter at 1 -> next cycle state RUN, busy=0, scoreboard empty.
